// File: rtl/disc_isqrt.sv
// disc_isqrt: sequential restoring integer square root, two operand bits per cycle.
// Optional ISQRT_ROUND_EN rounds the root to nearest, saturating at all-ones.
module disc_isqrt #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);
  localparam int H  = WIDTH / 2;
  localparam int CW = H > 1 ? $clog2(H) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t         state;
  logic [WIDTH-1:0] opr;
  logic [H-1:0]   root_p, root_n, root_o;
  logic [H-1:0]   rem_p;
  logic [H:0]     rem_n;
  logic [H+1:0]   trial, cmp, diff;
  logic [CW-1:0]  cnt;
  logic           ge;
  always_comb begin
    trial  = {rem_p, opr[WIDTH-1 -: 2]};
    cmp    = {root_p, 2'b01};
    ge     = trial >= cmp;
    diff   = ge ? trial - cmp : trial;
    rem_n  = diff[H:0];
    root_n = {root_p[H-2:0], ge};
`ifdef ISQRT_ROUND_EN
    root_o = (rem_n > {1'b0, root_n} && !(&root_n)) ? root_n + 1'b1 : root_n;
`else
    root_o = root_n;
`endif
  end
  // partial remainder stays below 2^H until the final iteration, which feeds rem directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opr    <= '0;
      root_p <= '0;
      rem_p  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      root   <= '0;
      rem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opr    <= x;
            root_p <= '0;
            rem_p  <= '0;
            cnt    <= CW'(H - 1);
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          opr    <= opr << 2;
          root_p <= root_n;
          rem_p  <= rem_n[H-1:0];
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            root  <= root_o;
            rem   <= rem_n;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_disc_isqrt.sv
// tb_disc_isqrt: directed and randomized checks of disc_isqrt (WIDTH=8) against an arithmetic model.
module tb_disc_isqrt;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic       busy, done;
  logic [3:0] root;
  logic [4:0] rem;
  int errors = 0;
  int checks = 0;

  disc_isqrt #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x),
    .busy(busy), .done(done), .root(root), .rem(rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fl_sqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int exp_root(input int v);
    int r = fl_sqrt(v);
`ifdef ISQRT_ROUND_EN
    if (v - r * r > r && r < 15) r++;
`endif
    return r;
  endfunction

  // wait for done from the negedge after the accept edge; returns cycles taken
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = int'(busy);
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bcnt += int'(busy);
    end
  endtask

  task automatic op(input logic [7:0] v, input string tag);
    int cyc, bcnt;
    @(negedge clk);
    start = 1'b1;
    x = v;
    @(negedge clk);
    start = 1'b0;
    x = ~v;
    wait_done(cyc, bcnt);
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " root"}, root, exp_root(v));
    chk({tag, " rem"}, rem, v - fl_sqrt(v) * fl_sqrt(v));
    checks++;
    assert (rem <= 2 * fl_sqrt(v)) else begin
      errors++;
      $error("FAIL %s rem_bound: got %0d expected <= %0d", tag, rem, 2 * fl_sqrt(v));
    end
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " busy_cycles"}, bcnt, 5);
    chk({tag, " busy_idle"}, busy, 0);
  endtask

  initial begin
    int cyc, bcnt, seen;
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst root", root, 0);
    chk("rst rem", rem, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(8'd144, "x144");
    op(8'd200, "x200");
    op(8'd0, "x0");
    op(8'd255, "x255");
    op(8'd211, "x211");
    op(8'd210, "x210");

    // start held high across two operations; x changes during CALC are ignored
    @(negedge clk);
    start = 1'b1;
    x = 8'd49;
    @(negedge clk);
    x = 8'd81;
    wait_done(cyc, bcnt);
    chk("held1 latency", cyc, 4);
    chk("held1 root", root, 7);
    chk("held1 rem", rem, 0);
    @(negedge clk);
    chk("held gap busy", busy, 0);
    @(negedge clk);
    chk("held2 accepted", busy, 1);
    start = 1'b0;
    x = 8'd3;
    wait_done(cyc, bcnt);
    chk("held2 latency", cyc, 4);
    chk("held2 root", root, 9);
    chk("held2 rem", rem, 0);
    @(negedge clk);

    // reset after the second CALC edge of x=200 (previous result 9 still on outputs)
    @(negedge clk);
    start = 1'b1;
    x = 8'd200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst root", root, 0);
    chk("midrst rem", rem, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      seen += int'(done);
    end
    chk("midrst no_done", seen, 0);
    op(8'd16, "x16");

    for (int v = 0; v < 256; v++) op(8'(v), "sweep");
    for (int i = 0; i < 20; i++) op(8'($urandom_range(255)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
